// File: rtl/stim_pkg.sv
// stim_pkg: shared types and helpers for the stim_src stimulus source.
//   state_t    : FSM state encoding used by stim_src
//   LFSR_W     : LFSR register width
//   LFSR_MASK  : Galois feedback mask (taps 32,22,2,1)
//   lfsr_next  : one right-shift Galois step
package stim_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    STREAM    = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4
  } state_t;

  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/stim_src_lfsr.sv
// lfsr32_galois: 32-bit right-shift Galois LFSR, advances one step per enabled cycle.
// Ports:
//   clk   in   system clock
//   rst_n in   async active-low reset, loads SEED
//   en    in   advance enable
//   q     out  current LFSR value
// Parameters:
//   SEED  reset value, must be nonzero (an all-zero LFSR never leaves zero)
module lfsr32_galois
  import stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr32_galois: SEED must be nonzero");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/stim_src.sv
// stim_src: synthesizable upstream stimulus source. After reset it waits
// START_DELAY cycles, pulses start_o, streams BURST_LEN pseudo-random words
// over valid/ready, then waits for done_i (or TIMEOUT) and reports a sticky
// pass/fail result.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   async active-low reset; aborts any burst in progress
//   start_o    out  one-cycle start pulse to the consumer
//   data_o     out  stream word (low DATA_W bits of the LFSR)
//   valid_o    out  data_o valid
//   ready_i    in   consumer accepts the word when valid_o && ready_i
//   done_i     in   consumer completion (level or pulse), sampled in WAIT_DONE only
//   busy_o     out  high in START, STREAM and WAIT_DONE
//   finish_o   out  sticky, high from entry to FINISH
//   pass_o     out  sticky, 1 = done_i seen before timeout (valid with finish_o)
//   word_cnt_o out  words accepted so far, saturating
//   checksum_o out  running XOR of accepted words (optional)
//
// Optional feature: define STIM_SRC_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum_o is tied to zero.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | counting START_DELAY cycles after reset release
// START     | start_o high for one cycle
// STREAM    | valid_o high, one word per handshake
// WAIT_DONE | waiting for done_i, bounded by TIMEOUT
// FINISH    | terminal, result held until reset
module stim_src
  import stim_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                BURST_LEN   = 256,
  parameter int                START_DELAY = 16,
  parameter logic [LFSR_W-1:0] SEED        = 32'h0000_0001,
  parameter int                TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              start_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              done_i,
  output logic              busy_o,
  output logic              finish_o,
  output logic              pass_o,
  output logic [15:0]       word_cnt_o,
  output logic [31:0]       checksum_o
);

  if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_bad_burst
    $error("stim_src: BURST_LEN must be in 1..65535");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
    $error("stim_src: DATA_W must be in 1..32");
  end
  if (START_DELAY < 1 || TIMEOUT < 1) begin : g_bad_timer
    $error("stim_src: START_DELAY and TIMEOUT must be >= 1");
  end

  localparam logic [31:0] DLY_LAST  = 32'(START_DELAY - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
  localparam logic [15:0] LAST_WORD = 16'(BURST_LEN - 1);

  state_t            state;
  logic [31:0]       cnt;        // shared: start delay in IDLE, timeout in WAIT_DONE
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_nx;
  logic              accept;

  // valid_o is only ever high in STREAM, so the handshake needs no state term.
  assign accept  = valid_o && ready_i;
  assign lfsr_nx = lfsr_next(lfsr_q);
  assign busy_o  = (state == START) || (state == STREAM) || (state == WAIT_DONE);

  lfsr32_galois #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      start_o    <= 1'b0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      word_cnt_o <= '0;
      finish_o   <= 1'b0;
      pass_o     <= 1'b0;
    end else begin
      start_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cnt == DLY_LAST) begin
            state   <= START;
            start_o <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        START: begin
          state   <= STREAM;
          valid_o <= 1'b1;
          data_o  <= lfsr_q[DATA_W-1:0];
        end
        STREAM: begin
          if (accept) begin
            // Preload the next word so back-to-back accepts need no bubble.
            data_o <= lfsr_nx[DATA_W-1:0];
            if (word_cnt_o != 16'hFFFF) begin
              word_cnt_o <= word_cnt_o + 16'd1;
            end
            if (word_cnt_o == LAST_WORD) begin
              valid_o <= 1'b0;
              state   <= WAIT_DONE;
              cnt     <= '0;
            end
          end
        end
        WAIT_DONE: begin
          // done_i is checked first so it wins on the final timeout cycle.
          if (done_i) begin
            state    <= FINISH;
            finish_o <= 1'b1;
            pass_o   <= 1'b1;
          end else if (cnt == TO_LAST) begin
            state    <= FINISH;
            finish_o <= 1'b1;
            pass_o   <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        FINISH: begin
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef STIM_SRC_CHECKSUM_EN
  logic [31:0] data_ext;
  logic [31:0] checksum_q;

  always_comb begin
    data_ext               = '0;
    data_ext[DATA_W-1:0]   = data_o;
  end

  // Only accepted words contribute, so the sum freezes once STREAM ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q ^ data_ext;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_stim_src.sv
module tb_stim_src;

  localparam int BURST = 256;
  localparam int DLY   = 16;
  localparam int TMO   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_o, valid_o, busy_o, finish_o, pass_o;
  logic        ready_i = 1'b0;
  logic        done_i = 1'b0;
  logic [31:0] data_o, checksum_o;
  logic [15:0] word_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w [BURST];
  logic [31:0] exp_sum;

  always #5 clk = ~clk;

  stim_src #(
    .DATA_W      (32),
    .BURST_LEN   (BURST),
    .START_DELAY (DLY),
    .SEED        (32'h0000_0001),
    .TIMEOUT     (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_o    (start_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .done_i     (done_i),
    .busy_o     (busy_o),
    .finish_o   (finish_o),
    .pass_o     (pass_o),
    .word_cnt_o (word_cnt_o),
    .checksum_o (checksum_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference word sequence: Galois step divides by x with the tap polynomial.
  function automatic logic [31:0] model_step(input logic [31:0] l);
    logic [31:0] r;
    r = l / 2;
    if (l % 2 == 1) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    ready_i = 1'b0;
    done_i  = 1'b0;
    tick();
    tick();
    chk("rst_valid",   valid_o,    0);
    chk("rst_start",   start_o,    0);
    chk("rst_busy",    busy_o,     0);
    chk("rst_finish",  finish_o,   0);
    chk("rst_pass",    pass_o,     0);
    chk("rst_data",    data_o,     0);
    chk("rst_cnt",     word_cnt_o, 0);
    chk("rst_sum",     checksum_o, 0);
    rst_n = 1'b1;
  endtask

  // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random
  // dmode: 0 done after ddelay cycles, 1 never, 2 pulse during STREAM only
  task automatic run(input int rmode, input int dmode, input int ddelay,
                     input bit abort, output bit aborted);
    int idx = 0;
    int vcyc = 0;
    int budget = 3000;
    logic [31:0] expd;
    logic [31:0] sum_hold;
    bit rdy;
    aborted = 1'b0;
    do_reset();
    for (int i = 1; i <= DLY; i++) begin
      tick();
      chk("start_pulse", start_o, (i == DLY));
    end
    chk("busy_start", busy_o, 1);
    tick();
    chk("start_once", start_o, 0);
    chk("valid_first", valid_o, 1);
    while (valid_o && budget > 0) begin
      expd = (idx == 0) ? 32'h0000_0001 : (idx == 1) ? 32'h8020_0003 : exp_w[idx];
      chk("data", data_o, expd);
      if (idx % 37 == 0) chk("word_cnt_run", word_cnt_o, idx);
      if (abort && idx == 100) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", valid_o, 0);
        chk("abort_cnt",   word_cnt_o, 0);
        chk("abort_busy",  busy_o, 0);
        aborted = 1'b1;
        return;
      end
      done_i = (dmode == 2 && vcyc == 50);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (vcyc % 4 == 0) || (vcyc % 4 == 3);
        default: rdy = 1'($urandom % 2);
      endcase
      ready_i = rdy;
      tick();
      vcyc++;
      if (rdy) idx++;
      budget--;
    end
    ready_i = 1'b0;
    done_i  = 1'b0;
    if (budget == 0) chk("stream_budget", 0, 1);
    chk("words_accepted", idx, BURST);
    chk("word_cnt_end", word_cnt_o, BURST);
    chk("busy_wait", busy_o, 1);
    chk("finish_early", finish_o, 0);
    if (rmode == 0) chk("stream_cycles_nobp", vcyc, BURST);
    if (rmode == 1) chk("stream_cycles_bp", vcyc, 2 * BURST);
`ifdef STIM_SRC_CHECKSUM_EN
    chk("checksum", checksum_o, exp_sum);
`else
    chk("checksum", checksum_o, 0);
`endif
    sum_hold = exp_sum;
    if (dmode == 0) begin
      repeat (ddelay - 1) tick();
      chk("finish_before_done", finish_o, 0);
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk("done_finish", finish_o, 1);
      chk("done_pass",   pass_o,   1);
      chk("done_busy",   busy_o,   0);
    end else begin
      for (int i = 1; i <= TMO; i++) begin
        tick();
        if (i == TMO - 1) chk("timeout_not_yet", finish_o, 0);
      end
      chk("timeout_finish", finish_o, 1);
      chk("timeout_pass",   pass_o,   0);
      chk("timeout_busy",   busy_o,   0);
    end
    done_i = 1'b1;
    ready_i = 1'b1;
    repeat (5) tick();
    done_i = 1'b0;
    ready_i = 1'b0;
    chk("finish_sticky", finish_o, 1);
    chk("pass_sticky",   pass_o,   (dmode == 0));
    chk("valid_final",   valid_o,  0);
    chk("cnt_final",     word_cnt_o, BURST);
`ifdef STIM_SRC_CHECKSUM_EN
    chk("checksum_frozen", checksum_o, sum_hold);
`else
    chk("checksum_frozen", checksum_o, 0);
`endif
  endtask

  initial begin
    logic [31:0] l;
    bit ab;
    l = 32'h0000_0001;
    exp_sum = '0;
    for (int i = 0; i < BURST; i++) begin
      exp_w[i] = l;
      exp_sum  = exp_sum ^ l;
      l = model_step(l);
    end

    run(0, 0, 10, 1'b0, ab);                          // no backpressure, done 10 cycles late
    run(1, 0, TMO, 1'b0, ab);                         // backpressure, done on last timeout cycle
    run(2, 1, 0, 1'b0, ab);                           // done never: timeout fail
    run(2, 2, 0, 1'b0, ab);                           // early done ignored: timeout fail
    run(2, 0, 5, 1'b1, ab);                           // reset mid-burst at word 100
    chk("abort_taken", ab, 1);
    run(0, 0, int'($urandom_range(64, 1)), 1'b0, ab); // full burst restarts from SEED
    for (int k = 0; k < 3; k++) begin
      run(2, int'($urandom_range(1, 0)), int'($urandom_range(64, 1)), 1'b0, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
